img_stream_filter: RTL and testbench

- Parametrised successor to the fixed 8-bit/512-pixel image-processing top.
- Integrates a 4-line-buffer 3x3 window generator, a run-time selectable kernel and an output FIFO in native RTL (no vendor FIFO IP).
- Sits between the DMA controller's AXI-Stream MM2S output and S2MM input.
- Raises a per-line interrupt whenever a line buffer is freed.

---
 rtl/img_stream_filter.sv | 202 ++++++++++++++++++++
 tb/tb_img_stream_filter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_filter.sv
// 3x3 streaming image filter: four-line buffer window generator, run-time kernel select,
// first-word-fall-through output FIFO and a per-line interrupt when a line buffer is freed.
//
// state  | meaning
// S_IDLE | waiting for three buffered lines and enough FIFO credit for a full output line
// S_READ | emitting one window per cycle for columns 1..IMG_W-2 of the current line
module img_stream_filter #(
  parameter int PW         = 8,
  parameter int IMG_W      = 512,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic          axi_clk,
  input  logic          axi_reset_n,
  input  logic [1:0]    i_mode,
  input  logic          i_data_valid,
  input  logic [PW-1:0] i_data,
  output logic          o_data_ready,
  output logic          o_data_valid,
  output logic [PW-1:0] o_data,
  input  logic          i_data_ready,
  output logic          o_interrupt
);

  localparam int CW  = $clog2(IMG_W);
  localparam int FCW = $clog2(4*IMG_W+1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int KW  = PW + 4;

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W-1);
  localparam logic [CW-1:0]  COL_END  = CW'(IMG_W-2);
  localparam logic [FCW-1:0] FC_FULL  = FCW'(4*IMG_W);
  localparam logic [FCW-1:0] FC_START = FCW'(3*IMG_W);
  localparam logic [FCW-1:0] FC_LINE  = FCW'(IMG_W);
  localparam logic [AW+1:0]  CREDIT   = (AW+2)'(FIFO_DEPTH-(IMG_W-2));
  localparam logic [KW-1:0]  PIX_MAX  = KW'((1 << PW) - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   lbuf [4][IMG_W];
  logic [CW-1:0]   wc, rc;
  logic [1:0]      wb, rb, mode_r;
  logic [FCW-1:0]  fc, fc_nxt;
  logic            accept, start, line_done;
  logic [AW+1:0]   used_plus;

  logic [PW-1:0]   win [3][3];
  logic            s1_valid;
  logic [1:0]      s1_mode;
  logic [PW-1:0]   s1_win [3][3];

  logic [KW-1:0]   q [3][3];
  logic [KW-1:0]   g_sum, gx_p, gx_n, gy_p, gy_n, gx_abs, gy_abs, mag;
  logic [PW-1:0]   k_out;

  logic [PW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wp, rp, fifo_used;
  logic            fifo_empty, pop;
  logic [PW-1:0]   last_r;

  assign accept       = i_data_valid && o_data_ready;
  assign o_data_ready = (fc < FC_FULL);

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wc <= '0;
      wb <= '0;
      fc <= '0;
    end else begin
      if (accept) begin
        if (wc == COL_LAST) begin
          wc <= '0;
          wb <= wb + 2'd1;
        end else begin
          wc <= wc + CW'(1);
        end
      end
      fc <= fc_nxt;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (accept) lbuf[wb][wc] <= i_data;
  end

  // Write side and line release may coincide; apply the net change.
  always_comb begin
    fc_nxt = fc;
    if (accept)    fc_nxt = fc_nxt + FCW'(1);
    if (line_done) fc_nxt = fc_nxt - FC_LINE;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    line_done = 1'b0;
    used_plus = {1'b0, fifo_used} + {{(AW+1){1'b0}}, s1_valid};
    case (state)
      S_IDLE: begin
        if (fc >= FC_START && used_plus <= CREDIT) begin
          state_nxt = S_READ;
          start     = 1'b1;
        end
      end
      S_READ: begin
        if (rc == COL_END) begin
          line_done = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state       <= S_IDLE;
      rc          <= CW'(1);
      rb          <= '0;
      mode_r      <= '0;
      o_interrupt <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_interrupt <= line_done;
      if (start) begin
        rc     <= CW'(1);
        mode_r <= i_mode;
      end else if (state == S_READ && !line_done) begin
        rc <= rc + CW'(1);
      end
      if (line_done) rb <= rb + 2'd1;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = lbuf[rb + 2'(r)][rc + CW'(c) - CW'(1)];
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) s1_valid <= 1'b0;
    else              s1_valid <= (state == S_READ);
  end

  always_ff @(posedge axi_clk) begin
    if (state == S_READ) begin
      s1_win  <= win;
      s1_mode <= mode_r;
    end
  end

  // Sobel magnitudes are formed as unsigned |a-b| so no signed arithmetic is needed.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        q[r][c] = KW'(s1_win[r][c]);
    g_sum  = q[0][0] + (q[0][1] << 1) + q[0][2]
           + (q[1][0] << 1) + (q[1][1] << 2) + (q[1][2] << 1)
           + q[2][0] + (q[2][1] << 1) + q[2][2];
    gx_p   = q[0][2] + (q[1][2] << 1) + q[2][2];
    gx_n   = q[0][0] + (q[1][0] << 1) + q[2][0];
    gy_p   = q[2][0] + (q[2][1] << 1) + q[2][2];
    gy_n   = q[0][0] + (q[0][1] << 1) + q[0][2];
    gx_abs = (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
    gy_abs = (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
    mag    = gx_abs + gy_abs;
    k_out  = '0;
    case (s1_mode)
      2'd0:    k_out = s1_win[1][1];
      2'd1:    k_out = PW'(g_sum >> 4);
      2'd2:    k_out = (mag > PIX_MAX) ? {PW{1'b1}} : PW'(mag);
      default: k_out = ~s1_win[1][1];
    endcase
  end

  assign fifo_used    = wp - rp;
  assign fifo_empty   = (wp == rp);
  assign o_data_valid = !fifo_empty;
  assign pop          = o_data_valid && i_data_ready;
  assign o_data       = fifo_empty ? last_r : fifo_mem[rp[AW-1:0]];

  always_ff @(posedge axi_clk) begin
    if (s1_valid) fifo_mem[wp[AW-1:0]] <= k_out;
  end

  // last_r keeps o_data steady once the FIFO drains.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wp     <= '0;
      rp     <= '0;
      last_r <= '0;
    end else begin
      if (s1_valid) wp <= wp + (AW+1)'(1);
      if (pop) begin
        rp     <= rp + (AW+1)'(1);
        last_r <= fifo_mem[rp[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_img_stream_filter.sv
// Directed bench for img_stream_filter (IMG_W=8, PW=8, FIFO_DEPTH=16) with an image-level
// reference model feeding an expected-output queue checked on every pop.
module tb_img_stream_filter;
  localparam int PW = 8;
  localparam int W  = 8;
  localparam int FD = 16;

  logic          axi_clk = 1'b0;
  logic          axi_reset_n = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic          i_data_valid = 1'b0;
  logic [PW-1:0] i_data = '0;
  logic          o_data_ready;
  logic          o_data_valid;
  logic [PW-1:0] o_data;
  logic          i_data_ready = 1'b1;
  logic          o_interrupt;

  img_stream_filter #(.PW(PW), .IMG_W(W), .FIFO_DEPTH(FD)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_mode(i_mode),
    .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready),
    .o_interrupt(o_interrupt)
  );

  always #5 axi_clk = ~axi_clk;

  int n_cmp = 0, n_fail = 0, cyc = 0, irq_cnt = 0;
  int img[$];
  int exp_q[$];
  int got[$];
  int got_cyc[$];
  int line_mode[8];
  bit prev_stall = 0;
  bit prev_irq = 0;
  logic [PW-1:0] prev_data = '0;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(posedge axi_clk) cyc <= cyc + 1;

  // Image-level reference: output line k is built from input rows k..k+2.
  function automatic int px(int k, int r, int c);
    return img[(k + r) * W + c];
  endfunction

  function automatic int model_out(int mode, int k, int col);
    int s, gx, gy, wt;
    s = 0; gx = 0; gy = 0;
    case (mode)
      0: return px(k, 1, col);
      1: begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            s += px(k, r, col + c - 1) * ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
        return (s >> 4) & 255;
      end
      2: begin
        for (int i = 0; i < 3; i++) begin
          wt = (i == 1) ? 2 : 1;
          gx += wt * (px(k, i, col + 1) - px(k, i, col - 1));
          gy += wt * (px(k, 2, col + i - 1) - px(k, 0, col + i - 1));
        end
        s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        return (s > 255) ? 255 : s;
      end
      default: return 255 - px(k, 1, col);
    endcase
  endfunction

  task automatic build_exp(input int nlines);
    exp_q.delete();
    for (int k = 0; k < nlines; k++)
      for (int col = 1; col <= W - 2; col++)
        exp_q.push_back(model_out(line_mode[k], k, col));
  endtask

  always @(negedge axi_clk) begin
    #1;
    if (!axi_reset_n) begin
      prev_stall = 0;
      prev_irq = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", o_data_valid, 1);
        check("stall_data_held", o_data, prev_data);
      end
      if (o_interrupt) begin
        irq_cnt++;
        check("irq_one_cycle", prev_irq, 0);
      end
      prev_irq = o_interrupt;
      if (o_data_valid && i_data_ready) begin
        got.push_back(o_data);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", o_data);
        end else begin
          check("stream", o_data, exp_q.pop_front());
        end
      end
      prev_stall = o_data_valid && !i_data_ready;
      prev_data = o_data;
    end
  end

  task automatic do_reset();
    @(negedge axi_clk);
    axi_reset_n = 1'b0;
    #2;
    check("rst_valid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_irq", o_interrupt, 0);
    exp_q.delete();
    got.delete();
    got_cyc.delete();
    irq_cnt = 0;
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    #2;
    check("rel_ready", o_data_ready, 1);
    check("rel_valid", o_data_valid, 0);
    check("rel_data", o_data, 0);
  endtask

  task automatic feed(input int first, input int last, input bit stall_exit, output int next_idx);
    int i;
    int idle;
    i = first;
    idle = 0;
    while (i < last && idle < 40) begin
      @(negedge axi_clk);
      i_data_valid = 1'b1;
      i_data = PW'(img[i]);
      if (o_data_ready) begin
        i++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    @(negedge axi_clk);
    i_data_valid = 1'b0;
    if (!stall_exit) check("feed_accepts", i, last);
    next_idx = i;
  endtask

  task automatic drain(input int nirq);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(negedge axi_clk);
      budget++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (4) @(negedge axi_clk);
    #2;
    check("irq_count", irq_cnt, nirq);
    check("empty_after", o_data_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int idx;
    int b;

    // Bypass: ramp pattern row*16+col
    do_reset();
    i_mode = 2'd0;
    i_data_ready = 1'b1;
    img.delete();
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img.push_back(r * 16 + c);
    line_mode[0] = 0;
    build_exp(1);
    check("pin_bypass_first", exp_q[0], 17);
    check("pin_bypass_last", exp_q[5], 22);
    feed(0, 24, 0, idx);
    drain(1);
    check("bypass_count", got.size(), 6);
    if (got.size() == 6) begin
      for (int i = 0; i < 6; i++) check("bypass_literal", got[i], 17 + i);
      check("bypass_back_to_back", got_cyc[5] - got_cyc[0], 5);
    end

    // Reset with a non-empty FIFO and a partial line, then three fresh lines
    do_reset();
    i_data_ready = 1'b0;
    img.delete();
    for (int r = 0; r < 4; r++) for (int c = 0; c < W; c++) img.push_back(r * 16 + c + 3);
    feed(0, 28, 0, idx);
    b = 0;
    while (!o_data_valid && b < 50) begin @(negedge axi_clk); b++; end
    check("pre_reset_valid", o_data_valid, 1);
    do_reset();
    i_data_ready = 1'b1;
    img.delete();
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img.push_back(250 - r * 20 - c * 7);
    line_mode[0] = 0;
    build_exp(1);
    feed(0, 24, 0, idx);
    drain(1);

    // Gaussian on a flat field, then on a single bright centre
    do_reset();
    i_mode = 2'd1;
    img.delete();
    for (int i = 0; i < 3 * W; i++) img.push_back(100);
    line_mode[0] = 1;
    build_exp(1);
    check("pin_gauss_flat", exp_q[3], 100);
    feed(0, 24, 0, idx);
    drain(1);

    do_reset();
    img.delete();
    for (int i = 0; i < 3 * W; i++) img.push_back((i == W + 3) ? 255 : 0);
    build_exp(1);
    check("pin_gauss_centre", exp_q[2], 63);
    check("pin_gauss_side", exp_q[1], 31);
    feed(0, 24, 0, idx);
    drain(1);

    // Sobel on a vertical edge, saturating
    do_reset();
    i_mode = 2'd2;
    img.delete();
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) img.push_back((c < 4) ? 0 : 255);
    line_mode[0] = 2;
    build_exp(1);
    check("pin_sobel_c3", exp_q[2], 255);
    check("pin_sobel_c4", exp_q[3], 255);
    check("pin_sobel_c1", exp_q[0], 0);
    check("pin_sobel_c5", exp_q[4], 0);
    feed(0, 24, 0, idx);
    drain(1);

    // Invert
    do_reset();
    i_mode = 2'd3;
    img.delete();
    for (int i = 0; i < 3 * W; i++) img.push_back(8'h3C);
    line_mode[0] = 3;
    build_exp(1);
    check("pin_invert", exp_q[0], 8'hC3);
    feed(0, 24, 0, idx);
    drain(1);

    // Sustained backpressure: two lines fit in FIFO credit, then input stalls at fc=32
    do_reset();
    i_mode = 2'd1;
    i_data_ready = 1'b0;
    img.delete();
    for (int r = 0; r < 8; r++) for (int c = 0; c < W; c++) img.push_back((r * 37 + c * 11) & 255);
    for (int k = 0; k < 6; k++) line_mode[k] = 1;
    build_exp(6);
    feed(0, 64, 1, idx);
    check("stall_accepted", idx, 48);
    check("stall_ready_low", o_data_ready, 0);
    check("stall_irq", irq_cnt, 2);
    check("stall_fifo_valid", o_data_valid, 1);
    @(negedge axi_clk);
    i_data_ready = 1'b1;
    feed(idx, 64, 0, idx);
    drain(6);
    check("bp_total_out", got.size(), 36);

    // Mode change mid-line takes effect on the following line only
    do_reset();
    i_mode = 2'd0;
    img.delete();
    for (int r = 0; r < 4; r++) for (int c = 0; c < W; c++) img.push_back(r * 16 + c);
    line_mode[0] = 0;
    line_mode[1] = 2;
    build_exp(2);
    check("pin_sobel_ramp", exp_q[6], 136);
    fork
      feed(0, 32, 0, idx);
      begin
        int bb;
        bb = 0;
        while (!o_data_valid && bb < 100) begin @(negedge axi_clk); #1; bb++; end
        check("toggle_point_valid", o_data_valid, 1);
        i_mode = 2'd2;
      end
    join
    drain(2);
    check("toggle_total_out", got.size(), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
